// File: rtl/fp_mul_iter_pkg.sv
// Shared binary64 constants, FSM state type and packing helper for the
// iterative FP multiplier.
package fp64_pkg;

    localparam int EXP_W      = 11;
    localparam int MAN_W      = 52;
    localparam int BIAS       = 1023;
    localparam int FP_MUL_LAT = 57;

    localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] FP64_PINF = 64'h7FF0_0000_0000_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_MULT   = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4
    } state_e;

    // Assemble a binary64 word from its fields.
    function automatic logic [63:0] fp64_pack(input logic sign,
                                              input logic [EXP_W-1:0] exp,
                                              input logic [MAN_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_mul_iter_if.sv
// valid/finish FP-operator handshake: master is the calling FSM, slave is
// the operator.
interface fp_mul_iter_if #(parameter int DBL_WIDTH = 64);
    logic                 valid;
    logic [DBL_WIDTH-1:0] a;
    logic [DBL_WIDTH-1:0] b;
    logic [DBL_WIDTH-1:0] result;
    logic                 finish;
    logic                 busy;

    modport master (output valid, output a, output b,
                    input result, input finish, input busy);
    modport slave  (input valid, input a, input b,
                    output result, output finish, output busy);
endinterface

// File: rtl/fp_mul_iter_mant.sv
// 53x53 radix-2 shift-add mantissa multiplier. One multiplier bit is
// consumed per step; the product settles after STEPS steps.
module mant_mul_iter #(
    parameter int STEPS = 53
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [52:0]  multiplicand,
    input  logic [52:0]  multiplier,
    input  logic         step,
    output logic [105:0] product,
    output logic         done
);

    localparam logic [5:0] LAST = 6'(STEPS - 1);

    logic [52:0]  mcand_r;
    logic [105:0] prod_r;
    logic [5:0]   cnt_r;
    logic [53:0]  sum_s;

    // Upper half plus the multiplicand when the current multiplier bit is set.
    assign sum_s = {1'b0, prod_r[105:53]} + (prod_r[0] ? {1'b0, mcand_r} : 54'd0);

    // Load operands, then add-and-shift right once per enabled step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= 53'd0;
            prod_r  <= 106'd0;
            cnt_r   <= 6'd0;
        end else if (load) begin
            mcand_r <= multiplicand;
            prod_r  <= {53'd0, multiplier};
            cnt_r   <= 6'd0;
        end else if (step) begin
            prod_r <= {sum_s, prod_r[52:1]};
            cnt_r  <= (cnt_r == LAST) ? 6'd0 : cnt_r + 6'd1;
        end else begin
            prod_r <= prod_r;
            cnt_r  <= cnt_r;
        end
    end

    assign product = prod_r;
    assign done    = step && (cnt_r == LAST);

endmodule

// File: rtl/fp_mul_iter.sv
// IEEE-754 binary64 multiplier with a fixed 57-cycle valid-to-finish
// latency. Every operand, special or not, walks the same state sequence.
module fp_mul_iter
    import fp64_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    fp_mul_iter_if.slave    bus
);

    state_e             state_r;
    logic [63:0]        a_r;
    logic [63:0]        b_r;
    logic               sign_r;
    logic               special_r;
    logic [63:0]        special_val_r;
    logic signed [12:0] exp_r;
    logic [52:0]        man_r;
    logic               guard_r;
    logic               sticky_r;
    logic [63:0]        result_r;
    logic               finish_r;
    logic               busy_r;

    // Operand fields and classification (subnormals are flushed to zero).
    logic [EXP_W-1:0]   ea_s, eb_s;
    logic [MAN_W-1:0]   fa_s, fb_s;
    logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic               is_nan_s, is_inf_s, is_zero_s, sign_s;
    logic [52:0]        ma_s, mb_s;
    logic signed [12:0] exp_sum_s;
    logic [63:0]        special_val_s;

    assign ea_s     = a_r[62:52];
    assign eb_s     = b_r[62:52];
    assign fa_s     = a_r[51:0];
    assign fb_s     = b_r[51:0];
    assign a_zero_s = (ea_s == 11'd0);
    assign b_zero_s = (eb_s == 11'd0);
    assign a_inf_s  = (ea_s == 11'h7FF) && (fa_s == 52'd0);
    assign b_inf_s  = (eb_s == 11'h7FF) && (fb_s == 52'd0);
    assign a_nan_s  = (ea_s == 11'h7FF) && (fa_s != 52'd0);
    assign b_nan_s  = (eb_s == 11'h7FF) && (fb_s != 52'd0);
    assign sign_s   = a_r[63] ^ b_r[63];
    assign is_nan_s = a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s);
    assign is_inf_s = a_inf_s || b_inf_s;
    assign is_zero_s = a_zero_s || b_zero_s;
    assign ma_s     = a_zero_s ? 53'd0 : {1'b1, fa_s};
    assign mb_s     = b_zero_s ? 53'd0 : {1'b1, fb_s};
    assign exp_sum_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - $signed(13'(BIAS));

    // Pick the forced result for NaN / infinity / zero operands.
    always_comb begin
        special_val_s = 64'd0;
        if (is_nan_s) begin
            special_val_s = FP64_QNAN;
        end else if (is_inf_s) begin
            special_val_s = FP64_PINF | {sign_s, 63'd0};
        end else begin
            special_val_s = {sign_s, 63'd0};
        end
    end

    // Mantissa engine.
    logic [105:0] prod_s;
    logic         mm_done_s;
    logic         mm_load_s;
    logic         mm_step_s;

    assign mm_load_s = (state_r == S_UNPACK);
    assign mm_step_s = (state_r == S_MULT);

    mant_mul_iter #(.STEPS(FP_MUL_LAT - 4)) u_mant (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (mm_load_s),
        .multiplicand (ma_s),
        .multiplier   (mb_s),
        .step         (mm_step_s),
        .product      (prod_s),
        .done         (mm_done_s)
    );

    // Normalisation: product lies in [2^104, 2^106) for normal operands.
    logic        hi_s;
    logic [52:0] norm_man_s;
    logic        norm_guard_s;
    logic        norm_sticky_s;

    assign hi_s          = prod_s[105];
    assign norm_man_s    = hi_s ? prod_s[105:53] : prod_s[104:52];
    assign norm_guard_s  = hi_s ? prod_s[52] : prod_s[51];
    assign norm_sticky_s = hi_s ? (|prod_s[51:0]) : (|prod_s[50:0]);

    // Round to nearest, ties to even; a carry-out bumps the exponent.
    logic               round_up_s;
    logic [53:0]        man_rnd_s;
    logic signed [12:0] exp_fin_s;
    logic [MAN_W-1:0]   frac_s;
    logic [63:0]        packed_s;

    assign round_up_s = guard_r && (sticky_r || man_r[0]);
    assign man_rnd_s  = {1'b0, man_r} + {53'd0, round_up_s};
    assign exp_fin_s  = exp_r + (man_rnd_s[53] ? 13'sd1 : 13'sd0);
    assign frac_s     = man_rnd_s[53] ? man_rnd_s[52:1] : man_rnd_s[51:0];

    // Final packing with overflow to infinity and flush-to-zero underflow.
    always_comb begin
        packed_s = 64'd0;
        if (special_r) begin
            packed_s = special_val_r;
        end else if (exp_fin_s >= 13'sd2047) begin
            packed_s = FP64_PINF | {sign_r, 63'd0};
        end else if (exp_fin_s <= 13'sd0) begin
            packed_s = {sign_r, 63'd0};
        end else begin
            packed_s = fp64_pack(sign_r, exp_fin_s[10:0], frac_s);
        end
    end

    // Operator FSM: sequences unpack, multiply, normalise and round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            a_r           <= 64'd0;
            b_r           <= 64'd0;
            sign_r        <= 1'b0;
            special_r     <= 1'b0;
            special_val_r <= 64'd0;
            exp_r         <= 13'sd0;
            man_r         <= 53'd0;
            guard_r       <= 1'b0;
            sticky_r      <= 1'b0;
            result_r      <= 64'd0;
            finish_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            finish_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        busy_r  <= 1'b1;
                        state_r <= S_UNPACK;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                S_UNPACK: begin
                    sign_r        <= sign_s;
                    special_r     <= is_nan_s || is_inf_s || is_zero_s;
                    special_val_r <= special_val_s;
                    exp_r         <= exp_sum_s;
                    state_r       <= S_MULT;
                end
                S_MULT: begin
                    if (mm_done_s) begin
                        state_r <= S_NORM;
                    end else begin
                        state_r <= S_MULT;
                    end
                end
                S_NORM: begin
                    man_r    <= norm_man_s;
                    guard_r  <= norm_guard_s;
                    sticky_r <= norm_sticky_s;
                    exp_r    <= exp_r + (hi_s ? 13'sd1 : 13'sd0);
                    state_r  <= S_ROUND;
                end
                S_ROUND: begin
                    result_r <= packed_s;
                    finish_r <= 1'b1;
                    state_r  <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.finish = finish_r;
    assign bus.busy   = busy_r;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed bench for fp_mul_iter: a table of operand/product vectors plus
// hand-written sequences for overlap, back-to-back, dual-instance and reset.
module tb_fp_mul_iter;

    logic clk;
    logic rst_n;

    fp_mul_iter_if bus ();
    fp_mul_iter_if bus2 ();

    fp_mul_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fp_mul_iter dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[13];

    int checks = 0;
    int errors = 0;

    int          fin_cnt;
    int          fin_at[4];
    logic [63:0] fin_res[4];
    int          busy_err;
    logic [63:0] mid_res;
    logic        rst_fin, rst_busy;
    logic [63:0] rst_res;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Launch one op in cycle 0, optionally a second valid at extra_k and a
    // 2-cycle reset at rst_k; observe ncyc cycles after launch.
    task automatic drive(input logic [63:0] a0, input logic [63:0] b0,
                         input int extra_k, input logic [63:0] a1, input logic [63:0] b1,
                         input int rst_k, input int ncyc);
        fin_cnt  = 0;
        busy_err = 0;
        mid_res  = 64'd0;
        for (int i = 0; i < 4; i++) begin
            fin_at[i]  = -1;
            fin_res[i] = 64'd0;
        end
        @(negedge clk);
        bus.valid = 1'b1;
        bus.a     = a0;
        bus.b     = b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            bus.valid = 1'b0;
            if (k == rst_k) rst_n = 1'b0;
            if (k == rst_k + 2) rst_n = 1'b1;
            #1;
            if (k == rst_k) begin
                rst_fin  = bus.finish;
                rst_busy = bus.busy;
                rst_res  = bus.result;
            end
            if (bus.finish) begin
                if (fin_cnt < 4) begin
                    fin_at[fin_cnt]  = k;
                    fin_res[fin_cnt] = bus.result;
                end
                fin_cnt++;
            end
            if (extra_k < 0 && rst_k < 0 && (bus.busy !== (k <= 57))) busy_err++;
            if (k == 100) mid_res = bus.result;
            if (k == extra_k) begin
                bus.valid = 1'b1;
                bus.a     = a1;
                bus.b     = b1;
            end
        end
    endtask

    int fa, fb;
    logic [63:0] ra, rb;

    initial begin
        vecs[0]  = '{64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000}; // 2*3
        vecs[1]  = '{64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002}; // (1+u)^2
        vecs[2]  = '{64'hBFF8000000000000, 64'h3FF8000000000000, 64'hC002000000000000}; // -1.5*1.5
        vecs[3]  = '{64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000}; // inf*0
        vecs[4]  = '{64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000}; // overflow
        vecs[5]  = '{64'h0010000000000000, 64'h3CB0000000000000, 64'h0000000000000000}; // underflow
        vecs[6]  = '{64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000}; // NaN in
        vecs[7]  = '{64'h7FF0000000000000, 64'hC000000000000000, 64'hFFF0000000000000}; // inf*-2
        vecs[8]  = '{64'h8000000000000000, 64'h4014000000000000, 64'h8000000000000000}; // -0*5
        vecs[9]  = '{64'h0000000000000001, 64'h4000000000000000, 64'h0000000000000000}; // subnormal FTZ
        vecs[10] = '{64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002}; // tie -> up to even
        vecs[11] = '{64'h3FF0000000000003, 64'h3FF8000000000000, 64'h3FF8000000000004}; // tie -> stay even
        vecs[12] = '{64'h3FFFFFFFFFFFFFFF, 64'h3FFFFFFFFFFFFFFF, 64'h400FFFFFFFFFFFFE}; // (2-u)^2

        rst_n = 1'b0;
        bus.valid = 1'b0; bus.a = 64'd0; bus.b = 64'd0;
        bus2.valid = 1'b0; bus2.a = 64'd0; bus2.b = 64'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_result", bus.result, 64'd0);
        check("reset_finish", {63'd0, bus.finish}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: latency, single finish, busy window and product.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].a, vecs[i].b, -1, 64'd0, 64'd0, -100, 70);
            check($sformatf("vec%0d_latency", i), 64'(fin_at[0]), 64'd57);
            check($sformatf("vec%0d_finish_count", i), 64'(fin_cnt), 64'd1);
            check($sformatf("vec%0d_result", i), fin_res[0], vecs[i].exp);
            check($sformatf("vec%0d_busy_window", i), 64'(busy_err), 64'd0);
        end

        // Two instances launched together finish together.
        fa = -1; fb = -1; ra = 64'd0; rb = 64'd0;
        @(negedge clk);
        bus.valid  = 1'b1; bus.a  = 64'h4000000000000000; bus.b  = 64'h4008000000000000;
        bus2.valid = 1'b1; bus2.a = 64'h7FF0000000000000; bus2.b = 64'h0000000000000000;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            bus.valid = 1'b0;
            bus2.valid = 1'b0;
            #1;
            if (bus.finish && fa < 0) begin fa = k; ra = bus.result; end
            if (bus2.finish && fb < 0) begin fb = k; rb = bus2.result; end
        end
        check("dual_latency_a", 64'(fa), 64'd57);
        check("dual_latency_b", 64'(fb), 64'd57);
        check("dual_result_a", ra, 64'h4018000000000000);
        check("dual_result_b", rb, 64'h7FF8000000000000);

        // valid while busy is ignored.
        drive(64'h4000000000000000, 64'h4008000000000000, 10,
              64'h4014000000000000, 64'h401C000000000000, -100, 80);
        check("ignore_finish_count", 64'(fin_cnt), 64'd1);
        check("ignore_latency", 64'(fin_at[0]), 64'd57);
        check("ignore_result", fin_res[0], 64'h4018000000000000);

        // valid in the finish cycle is accepted.
        drive(64'h4000000000000000, 64'h4008000000000000, 57,
              64'hBFF8000000000000, 64'h3FF8000000000000, -100, 125);
        check("b2b_finish_count", 64'(fin_cnt), 64'd2);
        check("b2b_first_latency", 64'(fin_at[0]), 64'd57);
        check("b2b_second_latency", 64'(fin_at[1]), 64'd114);
        check("b2b_first_result", fin_res[0], 64'h4018000000000000);
        check("b2b_result_held", mid_res, 64'h4018000000000000);
        check("b2b_second_result", fin_res[1], 64'hC002000000000000);

        // Reset mid-operation aborts without a finish.
        drive(64'h4000000000000000, 64'h4008000000000000, -1,
              64'd0, 64'd0, 20, 80);
        check("abort_result", rst_res, 64'd0);
        check("abort_finish", {63'd0, rst_fin}, 64'd0);
        check("abort_busy", {63'd0, rst_busy}, 64'd0);
        check("abort_no_finish", 64'(fin_cnt), 64'd0);

        // A fresh operation after the reset completes normally.
        drive(64'hBFF8000000000000, 64'h3FF8000000000000, -1, 64'd0, 64'd0, -100, 70);
        check("post_reset_latency", 64'(fin_at[0]), 64'd57);
        check("post_reset_result", fin_res[0], 64'hC002000000000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_iter.md
Name: fp_mul_iter

Overview:
- IEEE-754 binary64 multiplier: the responder side of the team's valid/finish FP-operator handshake used by the CMU datapath FSMs.
- Accepts one operand pair on a valid pulse and returns the product with a one-cycle finish pulse after a fixed latency.
- Mantissa product is computed by an iterative shift-add engine to save area. Several instances can be shared by one CMU FSM.
- Fixed latency is mandatory: callers launch two ops together and wait for both finishes in the same cycle.

Parameters:
- DBL_WIDTH, 64, operand/result width; only 64 supported.
- LAT, 57, cycles from valid-high cycle to finish-high cycle; localparam, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  one-cycle start pulse; a/b sampled on the same edge
- a  in  64  operand A, binary64
- b  in  64  operand B, binary64
- result  out  64  product; held stable from finish until the next finish
- finish  out  1  one-cycle pulse; result valid in this cycle
- busy  out  1  high from the cycle after valid is accepted until the finish cycle, inclusive

Behaviour:
- Reset (rst_n is asynchronous, active-low; clock is clk): state=S_IDLE, result=0, finish=0, busy=0, internal registers cleared.
- A reset mid-operation aborts the operation; no finish is issued.
- States:
  - S_IDLE: on valid, register a/b, go to S_UNPACK.
  - S_UNPACK (1 cycle): split sign/exp/mantissa and insert the hidden 1. Subnormal inputs are flushed to zero. Classify zero/inf/NaN into a special flag. Load the multiplier.
  - S_MULT (53 cycles): one multiplier bit per cycle into a 106-bit accumulator. A 6-bit counter counts 0..52.
  - S_NORM (1 cycle): if product bit105=1, shift right 1 and set exp+1. Form exp = ea+eb-1023 (13-bit signed). Compute guard and sticky.
  - S_ROUND (1 cycle): round to nearest, ties to even. A mantissa carry-out increments exp. Pack, register result, pulse finish next cycle, return to S_IDLE.
- Latency:
  - valid high in cycle 0 → finish high in cycle 57 exactly.
  - Special-operand cases still traverse all states, so latency is identical for every operand.
- sign = sa XOR sb for every non-NaN result.
- Special cases:
  - Either input NaN, or inf×0 → canonical qNaN 0x7FF8000000000000 (sign 0).
  - inf × nonzero → signed inf.
  - Zero (after FTZ) × finite → signed zero.
  - Biased exp ≥ 2047 after rounding → signed inf (0x7FF0000000000000 | sign).
  - Biased exp ≤ 0 → signed zero (flush-to-zero; no subnormal output).
- valid while busy=1 is ignored; the operand registers are not disturbed.
- valid in the finish cycle is accepted, because the FSM is in S_IDLE that cycle.
- No back-pressure: the caller must capture result by the next finish. result is not cleared on a new valid.
- finish is never high for two consecutive cycles.

Decomposition:
- Package fp64_pkg:
  - EXP_W=11, MAN_W=52, BIAS=1023
  - FP64_QNAN, FP64_PINF
  - FP_MUL_LAT=57
  - state_e enum {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND}
- Sub-module mant_mul_iter: 53×53 radix-2 shift-add multiplier.
  - Ports: load, multiplicand, multiplier, step enable, 106-bit product, done.
  - Instantiated once. The top FSM owns exponent, special-case, normalise and round logic.

Test Plan:
- a=0x4000000000000000 (2.0), b=0x4008000000000000 (3.0), valid at cycle 0 → finish exactly at cycle 57, result=0x4018000000000000 (6.0); busy high cycles 1–57.
- a=b=0x3FF0000000000001 (1+2^-52) → result=0x3FF0000000000002 (round-to-nearest drops 2^-104); a=0xBFF8000000000000, b=0x3FF8000000000000 → result=0xC002000000000000 (-2.25).
- Specials:
  - a=0x7FF0000000000000, b=0 → result=0x7FF8000000000000.
  - a=0x7FEFFFFFFFFFFFFF, b=0x4000000000000000 → result=0x7FF0000000000000.
  - a=0x0010000000000000, b=0x3CB0000000000000 → result=0x0000000000000000.
  - All three at latency 57.
- Two instances started in the same cycle, one with specials and one with normal operands → both finish pulses in the same cycle.
- valid pulsed again at cycle 10 with different operands → ignored, first result unchanged at cycle 57.
- valid pulsed at cycle 57 → accepted, second finish at cycle 114.
- rst_n low at cycle 20 for 2 cycles → finish, busy and result=0. No finish at cycle 57. A new valid after reset completes normally in 57 cycles.
